// File: rtl/addsub_unit_if.sv
// addsub_unit_if
//   Operand/result bundle for the 8-bit binary/BCD adder-subtractor.
//   master : drives a, b, add_sub, decen, carry_in; observes all results.
//   slave  : the datapath; consumes operands, drives the combinational
//            result (y, carry_out) and the registered result/flags
//            (y_q, carry_q, zero_q, neg_q, ovf_q).
interface addsub_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             add_sub;
    logic             decen;
    logic             carry_in;
    logic [WIDTH-1:0] y;
    logic             carry_out;
    logic [WIDTH-1:0] y_q;
    logic             carry_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;

    modport master (
        output a, b, add_sub, decen, carry_in,
        input  y, carry_out, y_q, carry_q, zero_q, neg_q, ovf_q
    );

    modport slave (
        input  a, b, add_sub, decen, carry_in,
        output y, carry_out, y_q, carry_q, zero_q, neg_q, ovf_q
    );
endinterface

// File: rtl/addsub_unit.sv
// addsub_unit
//   8-bit binary/BCD adder-subtractor for a 6502-compatible ALU.
//   Ports:
//     clk   : rising edge captures the registered result and flags
//     rst_n : asynchronous active-low reset of the registered outputs
//     bus   : addsub_unit_if.slave
//             a, b, add_sub (0 add / 1 sub), decen (1 = BCD), carry_in
//             y, carry_out            : combinational result
//             y_q, carry_q, zero_q,
//             neg_q, ovf_q            : result and Z/N/V captured every edge
//   Binary subtract treats carry_in as an active-high borrow; BCD subtract
//   uses the 6502 convention (carry_in = 1 means no borrow). carry_out is
//   always 1 for carry (add) or no borrow (sub).
module addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    addsub_unit_if.slave  bus
);

    localparam logic [WIDTH-1:0] BCD_NINES = WIDTH'(8'h99);

    // Two-step decimal correction on the 9-bit raw sum. Each step wraps at
    // 9 bits, so a raw sum near 0x1FF can wrap during the low-digit fix.
    function automatic logic [WIDTH:0] bcd_adjust(input logic [WIDTH:0] raw,
                                                  input logic           lowc);
        logic [WIDTH:0] r;
        r = raw;
        if ((r[3:0] > 4'd9) || lowc)
            r = r + (WIDTH+1)'(9'h006);
        if ((r[7:4] > 4'd9) || r[WIDTH])
            r = r + (WIDTH+1)'(9'h060);
        return r;
    endfunction

    // Two's-complement overflow of a + bb (+ carry) judged from the
    // uncorrected sum: like-signed operands producing a different sign.
    function automatic logic overflow(input logic signed [WIDTH-1:0] a_s,
                                      input logic signed [WIDTH-1:0] bb_s,
                                      input logic signed [WIDTH-1:0] s_s);
        return ((a_s < 0) == (bb_s < 0)) && ((s_s < 0) != (a_s < 0));
    endfunction

    logic [WIDTH-1:0]        bb;
    logic                    cin_eff;
    logic [WIDTH:0]          raw_sum;
    logic [4:0]              low_sum;
    logic [WIDTH:0]          bcd_sum;
    logic [WIDTH-1:0]        y_p0;
    logic                    co_p0;
    logic                    ovf_p0;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] bb_s;
    logic signed [WIDTH-1:0] s_s;

    logic [WIDTH-1:0]        y_p1;
    logic                    co_p1;
    logic                    zero_p1;
    logic                    neg_p1;
    logic                    ovf_p1;

    // Stage p0: combinational add/subtract and decimal correction.
    // Every mode reduces to a + bb + cin_eff. Binary subtract is
    // a + ~b + ~borrow, whose bit 8 is already the "no borrow" carry.
    // BCD subtract adds the nines' complement of b with the 6502 carry.
    always_comb begin
        bb      = bus.b;
        cin_eff = bus.carry_in;
        if (bus.add_sub) begin
            if (bus.decen) begin
                bb = BCD_NINES - bus.b;
            end else begin
                bb      = ~bus.b;
                cin_eff = ~bus.carry_in;
            end
        end

        raw_sum = {1'b0, bus.a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin_eff};
        low_sum = {1'b0, bus.a[3:0]} + {1'b0, bb[3:0]} + {4'b0, cin_eff};
        bcd_sum = bcd_adjust(raw_sum, low_sum[4]);

        if (bus.decen) begin
            y_p0  = bcd_sum[WIDTH-1:0];
            co_p0 = bcd_sum[WIDTH];
        end else begin
            y_p0  = raw_sum[WIDTH-1:0];
            co_p0 = raw_sum[WIDTH];
        end

        a_s    = bus.a;
        bb_s   = bb;
        s_s    = raw_sum[WIDTH-1:0];
        ovf_p0 = overflow(a_s, bb_s, s_s);
    end

    assign bus.y         = y_p0;
    assign bus.carry_out = co_p0;

    // Stage p1: result and status flags captured every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p1    <= '0;
            co_p1   <= 1'b0;
            zero_p1 <= 1'b0;
            neg_p1  <= 1'b0;
            ovf_p1  <= 1'b0;
        end else begin
            y_p1    <= y_p0;
            co_p1   <= co_p0;
            zero_p1 <= (y_p0 == '0);
            neg_p1  <= y_p0[WIDTH-1];
            ovf_p1  <= ovf_p0;
        end
    end

    assign bus.y_q     = y_p1;
    assign bus.carry_q = co_p1;
    assign bus.zero_q  = zero_p1;
    assign bus.neg_q   = neg_p1;
    assign bus.ovf_q   = ovf_p1;

endmodule

// File: tb/tb_addsub_unit.sv
// tb_addsub_unit
//   Directed and randomized bench for addsub_unit. Expected values come from
//   an integer-arithmetic reference model of the adder-subtractor rules.
module tb_addsub_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    addsub_unit_if #(.WIDTH(8)) bus ();

    addsub_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int y;
        int co;
        int v;
    } res_t;

    typedef struct {
        int a;
        int b;
        int sub;
        int dec;
        int cin;
        int ey;
        int eco;
    } spot_t;

    function automatic int sgn8(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic res_t model(input int a, input int b, input int sub,
                                   input int dec, input int cin);
        res_t res;
        int   s;
        int   sv;
        int   bb;
        int   r;
        if (dec == 0) begin
            if (sub == 0) begin
                s      = a + b + cin;
                res.y  = s % 256;
                res.co = (s > 255) ? 1 : 0;
                sv     = sgn8(a) + sgn8(b) + cin;
            end else begin
                s      = a - b - cin;
                res.y  = s & 255;
                res.co = (s >= 0) ? 1 : 0;
                sv     = sgn8(a) - sgn8(b) - cin;
            end
        end else begin
            bb = (sub != 0) ? ((153 - b) & 255) : b;
            r  = a + bb + cin;
            if ((r % 16) > 9 || ((a % 16) + (bb % 16) + cin) > 15)
                r = (r + 6) % 512;
            if (((r / 16) % 16) > 9 || r > 255)
                r = (r + 96) % 512;
            res.y  = r % 256;
            res.co = (r > 255) ? 1 : 0;
            sv     = sgn8(a) + sgn8(bb) + cin;
        end
        res.v = (sv > 127 || sv < -128) ? 1 : 0;
        return res;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input int sub,
                         input int dec, input int cin);
        bus.a        = 8'(a);
        bus.b        = 8'(b);
        bus.add_sub  = 1'(sub);
        bus.decen    = 1'(dec);
        bus.carry_in = 1'(cin);
    endtask

    // Apply one operation mid-cycle, check the combinational result, then
    // check the registered result and flags just after the capturing edge.
    task automatic do_op(input string tag, input int a, input int b,
                         input int sub, input int dec, input int cin);
        res_t m;
        m = model(a, b, sub, dec, cin);
        @(negedge clk);
        drive(a, b, sub, dec, cin);
        #1;
        chk({tag, ".y"},  int'(bus.y),         m.y);
        chk({tag, ".co"}, int'(bus.carry_out), m.co);
        @(posedge clk);
        #1;
        chk({tag, ".y_q"},    int'(bus.y_q),     m.y);
        chk({tag, ".carry_q"},int'(bus.carry_q), m.co);
        chk({tag, ".zero_q"}, int'(bus.zero_q),  (m.y == 0) ? 1 : 0);
        chk({tag, ".neg_q"},  int'(bus.neg_q),   (m.y > 127) ? 1 : 0);
        chk({tag, ".ovf_q"},  int'(bus.ovf_q),   m.v);
    endtask

    spot_t spots[11] = '{
        '{8'hFF, 8'h01, 0, 0, 0, 8'h00, 1},
        '{8'h03, 8'h05, 1, 0, 0, 8'hFE, 0},
        '{8'h05, 8'h03, 1, 0, 1, 8'h01, 1},
        '{8'h05, 8'h03, 1, 0, 0, 8'h02, 1},
        '{8'h45, 8'h38, 0, 1, 0, 8'h83, 0},
        '{8'h99, 8'h99, 0, 1, 1, 8'h99, 1},
        '{8'h50, 8'h50, 0, 1, 0, 8'h00, 1},
        '{8'h05, 8'h03, 1, 1, 1, 8'h02, 1},
        '{8'h05, 8'h03, 1, 1, 0, 8'h01, 1},
        '{8'h03, 8'h05, 1, 1, 1, 8'h98, 0},
        '{8'h00, 8'h00, 1, 1, 1, 8'h00, 1}
    };

    initial begin
        int a;
        int b;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Reset state of the registered outputs.
        #2;
        chk("rst.y_q",     int'(bus.y_q),     0);
        chk("rst.carry_q", int'(bus.carry_q), 0);
        chk("rst.zero_q",  int'(bus.zero_q),  0);
        chk("rst.neg_q",   int'(bus.neg_q),   0);
        chk("rst.ovf_q",   int'(bus.ovf_q),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Spot checks against fixed expected values, then full model check.
        foreach (spots[i]) begin
            @(negedge clk);
            drive(spots[i].a, spots[i].b, spots[i].sub, spots[i].dec, spots[i].cin);
            #1;
            chk($sformatf("spot%0d.y", i),  int'(bus.y),         spots[i].ey);
            chk($sformatf("spot%0d.co", i), int'(bus.carry_out), spots[i].eco);
            do_op($sformatf("spot%0d", i), spots[i].a, spots[i].b,
                  spots[i].sub, spots[i].dec, spots[i].cin);
        end

        // Flag corner cases.
        do_op("flag7F01", 8'h7F, 8'h01, 0, 0, 0);
        chk("flag7F01.fix_neg", int'(bus.neg_q), 1);
        chk("flag7F01.fix_ovf", int'(bus.ovf_q), 1);
        do_op("flag8080", 8'h80, 8'h80, 0, 0, 0);
        chk("flag8080.fix_zero", int'(bus.zero_q),  1);
        chk("flag8080.fix_cy",   int'(bus.carry_q), 1);
        chk("flag8080.fix_ovf",  int'(bus.ovf_q),   1);

        // Asynchronous reset between edges while 7F+01 is applied.
        @(negedge clk);
        drive(8'h7F, 8'h01, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.y_q",     int'(bus.y_q),     0);
        chk("arst.carry_q", int'(bus.carry_q), 0);
        chk("arst.zero_q",  int'(bus.zero_q),  0);
        chk("arst.neg_q",   int'(bus.neg_q),   0);
        chk("arst.ovf_q",   int'(bus.ovf_q),   0);
        chk("arst.y",       int'(bus.y),       8'h80);
        @(posedge clk);
        #1;
        chk("arst_hold.y_q", int'(bus.y_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.y_q",   int'(bus.y_q),   8'h80);
        chk("rel.neg_q", int'(bus.neg_q), 1);
        chk("rel.ovf_q", int'(bus.ovf_q), 1);

        // Mode switch within one cycle.
        @(negedge clk);
        drive(8'h09, 8'h01, 0, 0, 0);
        #1;
        chk("mode.bin_y", int'(bus.y), 8'h0A);
        bus.decen = 1'b1;
        #1;
        chk("mode.bcd_y", int'(bus.y), 8'h10);

        // Random binary operations.
        for (int i = 0; i < 300; i++) begin
            do_op("rbin", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), 0, int'($urandom_range(0, 1)));
        end

        // Random valid BCD operations.
        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(0, 9)) * 16 + int'($urandom_range(0, 9));
            b = int'($urandom_range(0, 9)) * 16 + int'($urandom_range(0, 9));
            do_op("rbcd", a, b, int'($urandom_range(0, 1)), 1, int'($urandom_range(0, 1)));
        end

        // Random non-BCD operands in decimal mode.
        for (int i = 0; i < 100; i++) begin
            do_op("rdec", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), 1, int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_unit.md
Name:
addsub_unit

Overview:
- 8-bit binary/BCD adder-subtractor datapath for the 6502-compatible CPU ALU.
- Combinational result and carry are available in the same cycle.
- A registered copy of the result plus Z/N/V status flags is captured on every rising clock edge for the flag/accumulator path.

Parameters:
- WIDTH, 8, operand width. Decimal mode is defined only for 8 (two BCD digits).

Ports:
- clk  in  1  system clock; rising edge captures the registered outputs.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  8  first operand / minuend.
- b  in  8  second operand / subtrahend.
- add_sub  in  1  0 = add, 1 = subtract.
- decen  in  1  1 = BCD (decimal) mode, 0 = binary mode.
- carry_in  in  1  carry/borrow input; meaning depends on mode (see Behaviour).
- y  out  8  combinational result.
- carry_out  out  1  combinational carry out; 1 = carry (add) or no borrow (sub).
- y_q  out  8  registered y.
- carry_q  out  1  registered carry_out.
- zero_q  out  1  registered (y == 0).
- neg_q  out  1  registered y[7].
- ovf_q  out  1  registered two's-complement overflow.

Behaviour:
- y and carry_out are purely combinational from a, b, add_sub, decen and carry_in. They have no dependence on clk or rst_n, and settle within the same cycle.
- Binary add (add_sub=0, decen=0): form the 9-bit sum a + b + carry_in. y = sum[7:0]; carry_out = sum[8].
- Binary subtract (add_sub=1, decen=0): carry_in is an active-high borrow.
  - Form d = a - b - carry_in, modulo 512. y = d[7:0].
  - carry_out = ~d[8], i.e. 1 when no borrow occurred.
  - Example: 5-3 with carry_in=0 gives y=02, carry_out=1.
- BCD add (add_sub=0, decen=1):
  - r = a + b + carry_in (9-bit).
  - lowc = carry out of a[3:0] + b[3:0] + carry_in.
  - If r[3:0] > 9 or lowc, then r = r + 0x06 (9-bit).
  - Then, if r[7:4] > 9 or r[8], r = r + 0x60 (9-bit, wraps).
  - y = r[7:0]; carry_out = r[8].
- BCD subtract (add_sub=1, decen=1): carry_in is 6502-style, where 1 = no borrow.
  - bi = 0x99 - b (8-bit).
  - Result is exactly the BCD add algorithm applied to (a, bi, carry_in).
  - carry_out = 1 means no borrow.
- Non-BCD operands in decimal mode: the same algorithm is applied unchanged. Results are deterministic, but are not specified as meaningful decimal values.
- Overflow, computed on the pre-adjust binary sum:
  - Let bb = b for add, ~b for binary subtract, and bi for BCD subtract.
  - V = (a[7] == bb[7]) && (s[7] != a[7]), where s is the 8-bit uncorrected sum.
- Registered outputs:
  - On each posedge clk with rst_n=1: y_q <= y; carry_q <= carry_out; zero_q <= (y == 0); neg_q <= y[7]; ovf_q <= V.
  - Latency is 1 cycle. There is no enable or handshake; capture happens every cycle.
- Reset: rst_n=0 immediately forces y_q=0, carry_q=0, zero_q=0, neg_q=0, ovf_q=0, regardless of clk.
  - A reset mid-operation discards the pending capture.
  - The first rising edge after rst_n rises captures the current inputs.
  - The combinational outputs y and carry_out are unaffected by reset.
- Mode or operand changes take effect combinationally. No state is carried between operations.

Test Plan:
- Exhaustive binary: all a,b in 0..255, add_sub in {0,1}, carry_in in {0,1}. Required: y=(a±b±carry_in)[7:0]; carry_out = sum[8] for add and ~diff[8] for subtract. Spot checks: FF+01,c0 -> y=00,co=1; 03-05,c0 -> y=FE,co=0; 05-03,c1 -> y=01,co=1.
- BCD add, all valid BCD pairs 00..99, both carry_in values. Spot checks: 45+38,c0 -> y=83,co=0; 99+99,c1 -> y=99,co=1; 50+50,c0 -> y=00,co=1.
- BCD subtract, all valid BCD pairs. Spot checks: 05-03,c1 -> y=02,co=1; 05-03,c0 -> y=01,co=1; 03-05,c1 -> y=98,co=0; 00-00,c1 -> y=00,co=1.
- Flags: binary add 7F+01,c0 -> after posedge y_q=80, neg_q=1, ovf_q=1, zero_q=0. Binary add 80+80,c0 -> y_q=00, zero_q=1, carry_q=1, ovf_q=1.
- Reset: drive rst_n=0 between clock edges while inputs are 7F+01 -> all registered outputs go to 0 immediately while y stays 80. Release rst_n -> next posedge loads y_q=80.
- Mode switch: toggle decen with a=09, b=01, c0 -> y=0A in binary mode and y=10 in BCD mode, in the same cycle.
